// File: rtl/traffic_pkg.sv
// Shared lane count, level encodings and the queue-depth to congestion-level mapping
// used by the sensor front end of the traffic light controller.
package traffic_pkg;

    localparam int NUM_LANES = 4;
    localparam int LEVEL_W   = 2;

    typedef enum logic [LEVEL_W-1:0] {
        LVL_EMPTY = 2'b00,
        LVL_LOW   = 2'b01,
        LVL_MED   = 2'b10,
        LVL_HIGH  = 2'b11
    } level_t;

    // Thresholds are minimum counts for each level, so they must be ascending.
    function automatic level_t q_to_level(input int q, input int lvl1, input int lvl2, input int lvl3);
        if (q < lvl1) begin
            return LVL_EMPTY;
        end else if (q < lvl2) begin
            return LVL_LOW;
        end else if (q < lvl3) begin
            return LVL_MED;
        end else begin
            return LVL_HIGH;
        end
    endfunction

endpackage

// File: rtl/lane_tracker.sv
// One lane: detector synchroniser and debounce, green-phase departure timer,
// saturating vehicle queue and registered congestion level.
module lane_tracker
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE = 3,
    parameter int DEPART   = 5,
    parameter int QMAX     = 15,
    parameter int LVL1     = 1,
    parameter int LVL2     = 4,
    parameter int LVL3     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               detect,
    input  logic               green,
    output logic [LEVEL_W-1:0] level,
    output logic               overflow
);

    localparam int QW = $clog2(QMAX + 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic [3:0]    deb_reg;
    logic          arrival_reg;
    logic [7:0]    timer_reg;
    logic [7:0]    timer_next;
    logic [QW-1:0] q_reg;
    level_t        level_reg;
    logic          overflow_reg;
    logic          run;
    logic          depart;

    // The timer only advances while there is something to send away.
    assign run    = green && (q_reg != '0);
    assign depart = run && (timer_reg == 8'(DEPART - 1));

    always_comb begin
        timer_next = timer_reg + 8'd1;
        if (!run || depart) begin
            timer_next = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_reg    <= 1'b0;
            sync2_reg    <= 1'b0;
            deb_reg      <= 4'd0;
            arrival_reg  <= 1'b0;
            timer_reg    <= 8'd0;
            q_reg        <= '0;
            level_reg    <= LVL_EMPTY;
            overflow_reg <= 1'b0;
        end else begin
            sync1_reg <= detect;
            sync2_reg <= sync1_reg;

            // Saturating at DEBOUNCE means a held detector yields exactly one arrival.
            if (!sync2_reg) begin
                deb_reg <= 4'd0;
            end else if (deb_reg != 4'(DEBOUNCE)) begin
                deb_reg <= deb_reg + 4'd1;
            end
            arrival_reg <= sync2_reg && (deb_reg == 4'(DEBOUNCE - 1));

            timer_reg <= timer_next;

            case ({arrival_reg, depart})
                2'b10: begin
                    if (q_reg == QW'(QMAX)) begin
                        overflow_reg <= 1'b1;
                    end else begin
                        q_reg <= q_reg + 1'b1;
                    end
                end
                2'b01:   q_reg <= q_reg - 1'b1;
                default: q_reg <= q_reg;
            endcase

            level_reg <= q_to_level(int'(q_reg), LVL1, LVL2, LVL3);
        end
    end

    assign level    = level_reg;
    assign overflow = overflow_reg;

endmodule

// File: rtl/lane_queue_encoder.sv
// Sensor-side front end: four lane trackers, illegal multi-green detection and
// packing of per-lane congestion levels onto the controller's sensors bus.
module lane_queue_encoder
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE = 3,
    parameter int DEPART   = 5,
    parameter int QMAX     = 15,
    parameter int LVL1     = 1,
    parameter int LVL2     = 4,
    parameter int LVL3     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_LANES:1]     detect,
    input  logic [NUM_LANES:1]     traffic,
    output logic [2*NUM_LANES:1]   sensors,
    output logic [NUM_LANES:1]     overflow,
    output logic                   green_err
);

    logic multi_green;
    logic green_err_reg;

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi_green = (traffic & (traffic - 1'b1)) != '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            green_err_reg <= 1'b0;
        end else if (multi_green) begin
            green_err_reg <= 1'b1;
        end
    end

    assign green_err = green_err_reg;

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic [LEVEL_W-1:0] lane_level;

            lane_tracker #(
                .DEBOUNCE (DEBOUNCE),
                .DEPART   (DEPART),
                .QMAX     (QMAX),
                .LVL1     (LVL1),
                .LVL2     (LVL2),
                .LVL3     (LVL3)
            ) u_lane (
                .clk      (clk),
                .rst      (rst),
                .detect   (detect[gi+1]),
                .green    (traffic[gi+1] && !multi_green),
                .level    (lane_level),
                .overflow (overflow[gi+1])
            );

            assign sensors[2*gi+2 -: 2] = lane_level;
        end
    endgenerate

endmodule

// File: tb/tb_lane_queue_encoder.sv
// Directed self-checking bench for lane_queue_encoder with default parameters.
module tb_lane_queue_encoder;

    logic       clk;
    logic       rst;
    logic [4:1] detect;
    logic [4:1] traffic;
    logic [8:1] sensors;
    logic [4:1] overflow;
    logic       green_err;

    int total;
    int bad;

    typedef struct {
        logic [4:1] det;
        logic [8:1] exp_sensors;
        logic [4:1] exp_ovf;
        logic       exp_gerr;
    } vec_t;

    vec_t vecs[8];

    lane_queue_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .detect    (detect),
        .traffic   (traffic),
        .sensors   (sensors),
        .overflow  (overflow),
        .green_err (green_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // One clean vehicle: 4 cycles high, then low long enough for sensors to settle.
    task automatic pulse(input logic [4:1] mask);
        detect = mask;
        tick(4);
        detect = 4'b0;
        tick(6);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        vecs[0] = '{4'b0001, 8'b0000_0101, 4'b0000, 1'b0};
        vecs[1] = '{4'b0001, 8'b0000_0101, 4'b0000, 1'b0};
        vecs[2] = '{4'b0001, 8'b0000_0101, 4'b0000, 1'b0};
        vecs[3] = '{4'b0001, 8'b0000_0110, 4'b0000, 1'b0};
        vecs[4] = '{4'b0001, 8'b0000_0110, 4'b0000, 1'b0};
        vecs[5] = '{4'b0001, 8'b0000_0110, 4'b0000, 1'b0};
        vecs[6] = '{4'b0001, 8'b0000_0110, 4'b0000, 1'b0};
        vecs[7] = '{4'b0001, 8'b0000_0111, 4'b0000, 1'b0};

        // Reset with hostile inputs present.
        rst     = 1'b0;
        detect  = 4'hF;
        traffic = 4'h1;
        tick(2);
        chk("reset_sensors", 32'(sensors), 32'h0);
        chk("reset_overflow", 32'(overflow), 32'h0);
        chk("reset_green_err", 32'(green_err), 32'h0);
        rst     = 1'b1;
        detect  = 4'h0;
        traffic = 4'h0;
        tick(4);
        chk("idle_sensors", 32'(sensors), 32'h0);

        // Glitch of 2 cycles on lane 2 is rejected.
        detect = 4'b0010;
        tick(2);
        detect = 4'b0000;
        tick(8);
        chk("glitch_ignored", 32'(sensors), 32'h0);

        // Qualifying assertion: level appears exactly 7 edges later.
        detect = 4'b0010;
        tick(6);
        chk("latency_edge6", 32'(sensors[4:3]), 32'h0);
        tick(1);
        chk("latency_edge7", 32'(sensors[4:3]), 32'h1);
        tick(12);
        chk("held_one_arrival", 32'(sensors[4:3]), 32'h1);
        detect = 4'b0000;
        tick(4);

        // Table: 8 vehicles on lane 1 step the level upward.
        for (int v = 0; v < 8; v++) begin
            pulse(vecs[v].det);
            chk($sformatf("vec%0d_sensors", v), 32'(sensors), 32'(vecs[v].exp_sensors));
            chk($sformatf("vec%0d_overflow", v), 32'(overflow), 32'(vecs[v].exp_ovf));
            chk($sformatf("vec%0d_green_err", v), 32'(green_err), 32'(vecs[v].exp_gerr));
        end

        // Drain lane 1: last departure at edge 40, level follows at edge 41.
        traffic = 4'b0001;
        tick(40);
        chk("drain_edge40", 32'(sensors[2:1]), 32'h1);
        tick(1);
        chk("drain_edge41", 32'(sensors), 32'h04);
        traffic = 4'b0000;
        tick(2);

        // Lane 3 to q=4.
        for (int p = 0; p < 4; p++) pulse(4'b0100);
        chk("lane3_q4", 32'(sensors), 32'h24);

        // Arrival and departure land on the same edge: level must never leave 10.
        detect = 4'b0100;
        tick(1);
        traffic = 4'b0100;
        for (int c = 0; c < 12; c++) begin
            tick(1);
            if (c == 4) traffic = 4'b0000;
            if (c == 5) detect = 4'b0000;
            chk($sformatf("simul_c%0d", c), 32'(sensors[6:5]), 32'h2);
        end

        // Saturation on lane 4.
        for (int p = 0; p < 17; p++) pulse(4'b1000);
        chk("sat_sensors", 32'(sensors), 32'hE4);
        chk("sat_overflow", 32'(overflow), 32'h8);
        traffic = 4'b1000;
        tick(80);
        traffic = 4'b0000;
        tick(2);
        chk("sat_drained", 32'(sensors), 32'h24);
        chk("sat_overflow_sticky", 32'(overflow), 32'h8);

        // Illegal green with lanes 1 and 3 occupied.
        pulse(4'b0001);
        pulse(4'b0001);
        chk("pre_illegal", 32'(sensors), 32'h25);
        chk("pre_illegal_gerr", 32'(green_err), 32'h0);
        traffic = 4'b0101;
        tick(1);
        chk("illegal_gerr_set", 32'(green_err), 32'h1);
        tick(9);
        traffic = 4'b0000;
        tick(2);
        chk("illegal_no_depart", 32'(sensors), 32'h25);
        chk("illegal_gerr_held", 32'(green_err), 32'h1);
        traffic = 4'b0001;
        tick(12);
        traffic = 4'b0000;
        chk("legal_resume", 32'(sensors), 32'h24);
        chk("legal_gerr_still", 32'(green_err), 32'h1);

        // Reset mid-operation discards everything.
        rst = 1'b0;
        tick(1);
        chk("midreset_sensors", 32'(sensors), 32'h0);
        chk("midreset_overflow", 32'(overflow), 32'h0);
        chk("midreset_green_err", 32'(green_err), 32'h0);
        rst = 1'b1;
        tick(3);
        chk("postreset_sensors", 32'(sensors), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lane_queue_encoder.md
Name: lane_queue_encoder

Overview:
- Sensor-side front end for the `traffic` light controller: drives the controller's `sensors[8:1]` bus and consumes its `traffic[4:1]` green outputs.
- Debounces four raw vehicle-detector lines and tracks a per-lane queue count: arrivals increment it, green-phase departures decrement it.
- Encodes each lane's queue depth into a 2-bit congestion level on `sensors`.

Parameters:
- DEBOUNCE, 3, consecutive high cycles required before a detector assertion counts as one vehicle (range 1..15).
- DEPART, 5, cycles of continuous green per departing vehicle (range 1..255).
- QMAX, 15, saturation value of each queue counter (range 8..255). Counter width = clog2(QMAX+1).
- LVL1, 1, minimum queue count for level 01.
- LVL2, 4, minimum queue count for level 10.
- LVL3, 8, minimum queue count for level 11.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous active-low reset
- detect  input  [4:1]  raw detector level per lane, asynchronous to clk
- traffic  input  [4:1]  green indication from controller, one-hot or zero
- sensors  output  [8:1]  lane i level on sensors[2i:2i-1]
- overflow  output  [4:1]  sticky per-lane flag: an arrival was dropped at QMAX
- green_err  output  1  sticky flag: more than one traffic bit was high

Behaviour:
Reset:
- rst is sampled on the rising clk edge; rst==0 resets all state.
- Reset values: queues=0, debounce counters=0, depart timers=0, sensors=8'b0, overflow=4'b0, green_err=0.
- Reset mid-operation discards all counts. Outputs read zero on the first edge after rst goes low.

Synchroniser:
- Each detect bit passes through a 2-flop synchroniser. That latency is included in every timing figure below.

Debounce, per lane:
- Counter increments while the synchronised detect is 1 and saturates at DEBOUNCE.
- Counter clears to 0 on any cycle the synchronised detect is 0.
- One arrival pulse is generated on the cycle the counter reaches DEBOUNCE.
- No further arrival is generated until detect falls and re-qualifies.
- Glitches shorter than DEBOUNCE cycles are ignored.

Departure, per lane:
- The depart timer runs only while traffic[i]==1, green_err condition is absent, and queue>0.
- The timer counts 0..DEPART-1. On the cycle it equals DEPART-1 a depart pulse fires and the timer reloads to 0.
- Losing green or reaching queue==0 clears the timer to 0. Partial progress is not retained.

Queue update, per lane, every cycle:
- Arrival only: q = min(q+1, QMAX). If q was already QMAX, set overflow[i].
- Departure only: q = q-1. Depart never fires at q==0.
- Arrival and departure in the same cycle: q unchanged, no overflow.
- Neither: hold.

Level encoding, registered:
- q<LVL1 → 00; q<LVL2 → 01; q<LVL3 → 10; otherwise 11.
- sensors reflects the queue value one cycle after the queue register updates.
- End-to-end latency from detect rising to a sensors change = 2 (sync) + DEBOUNCE + 1 (queue) + 1 (encode) cycles. Default: 7 cycles.

Green error:
- If traffic has two or more bits set, all departures are suppressed that cycle and green_err is set.
- green_err clears only on reset.
- traffic==0 (all red) is legal: no departures occur.

Independence:
- Lanes are fully independent. Simultaneous arrivals on all lanes are all counted.

Decomposition:
- Package traffic_pkg:
  - NUM_LANES=4
  - LEVEL_W=2
  - level encodings LVL_EMPTY=2'b00, LVL_LOW=2'b01, LVL_MED=2'b10, LVL_HIGH=2'b11
  - queue-to-level function
- Sub-module lane_tracker:
  - Contains synchroniser, debounce, depart timer, queue counter and level register.
  - Instantiated four times.
- Top level:
  - Contains green_err detection, sensors bit packing and overflow concatenation.

Test Plan:
- Reset: hold rst=0 for 2 cycles with detect=4'hF and traffic=4'h1 → sensors=0, overflow=0, green_err=0; a queue built before reset reads level 00 after reset.
- Debounce: lane 2 detect high for 2 cycles then low, then high for 3 cycles (DEBOUNCE=3) → exactly one arrival; sensors[4:3]=01 exactly 7 cycles after the second rising edge; sensors[4:3] stays 01 while detect is held high.
- Levels and departure: 8 clean pulses on lane 1 → sensors[2:1] steps 01, 01, 01, 10, 10, 10, 10, 11. Then traffic=4'b0001 for 40 cycles (DEPART=5) → queue 0, and sensors[2:1] returns to 00 one cycle after the queue reaches 0.
- Simultaneous events: lane 3 at q=4 with green active; an arrival qualifies on the same cycle the depart timer expires → q stays 4, sensors[6:5]=10 with no glitch.
- Saturation: 17 pulses on lane 4 with QMAX=15 → q=15, sensors[8:7]=11, overflow=4'b1000. overflow stays set after departures drain the queue, until reset.
- Illegal green: traffic=4'b0101 for 10 cycles with lanes 1 and 3 non-empty → no departures, green_err=1 and held; legal traffic=4'b0001 afterwards resumes departures on lane 1.
